// File: rtl/pipe_mem_pkg.sv
// Shared types for the IF/MEM memory arbiter: FSM states,
// grant owner and default address/data widths.
package pipe_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        IF_WAIT,
        D0_WAIT,
        D1_WAIT,
        EXC
    } state_e;

    typedef enum logic {
        GRANT_IF,
        GRANT_D
    } grant_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for arbiter stall statistics.
// Ports: clk, reset (async, active-low), inc (count enable), count.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbiter sharing one synchronous-read memory between fetch (IF) and
// data (MEM) requesters; sequences LW/SW and two-beat LDW/SDW.
// Ports: clk, reset (async active-low); if_req/if_addr -> if_ack/if_rdata;
// d_req/d_we/d_double/d_rd_odd/d_addr/d_wdata0/1 -> d_ack/d_exception/
// d_rdata0/1; mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata.
// Optional ARB_PERF_CNT_EN adds perf_if_wait/perf_d_wait stall counters.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_double,
    input  logic              d_rd_odd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata0,
    input  logic [DATA_W-1:0] d_wdata1,
    output logic              d_ack,
    output logic              d_exception,
    output logic [DATA_W-1:0] d_rdata0,
    output logic [DATA_W-1:0] d_rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_d_wait
`endif
);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [DATA_W-1:0] d_rdata0_q, d_rdata0_d;
    logic [DATA_W-1:0] d_rdata1_q, d_rdata1_d;
    logic              d_win;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        d_rdata0_d   = d_rdata0_q;
        d_rdata1_d   = d_rdata1_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        d_exception  = 1'b0;
        // Data wins when alone, or on a tie when fetch had the last grant.
        d_win = d_req && (!if_req || (last_grant_q == GRANT_IF));

        unique case (state_q)
            IDLE: begin
                if (d_win) begin
                    last_grant_d = GRANT_D;
                    if (d_double && d_rd_odd) begin
                        state_d = EXC;
                    end else begin
                        mem_en    = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata0;
                        state_d   = D0_WAIT;
                    end
                end else if (if_req) begin
                    last_grant_d = GRANT_IF;
                    mem_en       = 1'b1;
                    mem_addr     = if_addr;
                    state_d      = IF_WAIT;
                end
            end
            IF_WAIT: begin
                if_ack  = 1'b1;
                state_d = IDLE;
            end
            D0_WAIT: begin
                if (!d_we) begin
                    d_rdata0_d = mem_rdata;
                end
                if (d_double) begin
                    // Second beat wraps naturally at the top of the space.
                    mem_en    = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr + ADDR_W'(1);
                    mem_wdata = d_wdata1;
                    state_d   = D1_WAIT;
                end else begin
                    d_ack   = 1'b1;
                    state_d = IDLE;
                end
            end
            D1_WAIT: begin
                if (!d_we) begin
                    d_rdata1_d = mem_rdata;
                end
                d_ack   = 1'b1;
                state_d = IDLE;
            end
            EXC: begin
                d_ack       = 1'b1;
                d_exception = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            d_rdata0_q   <= '0;
            d_rdata1_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            d_rdata0_q   <= d_rdata0_d;
            d_rdata1_q   <= d_rdata1_d;
        end
    end

    assign if_rdata = mem_rdata;
    assign d_rdata0 = d_rdata0_q;
    assign d_rdata1 = d_rdata1_q;

`ifdef ARB_PERF_CNT_EN
    sat_counter #(.W(32)) u_perf_if (
        .clk   (clk),
        .reset (reset),
        .inc   (if_req && !if_ack),
        .count (perf_if_wait)
    );

    sat_counter #(.W(32)) u_perf_d (
        .clk   (clk),
        .reset (reset),
        .inc   (d_req && !d_ack),
        .count (perf_d_wait)
    );
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: per-cycle vector table plus
// hand sequences for arbitration fairness and mid-access reset.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_double = 1'b0;
    logic        d_rd_odd = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata0 = '0;
    logic [31:0] d_wdata1 = '0;
    logic        d_ack;
    logic        d_exception;
    logic [31:0] d_rdata0;
    logic [31:0] d_rdata1;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait;
    logic [31:0] perf_d_wait;
`endif

    pipe_mem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ack      (if_ack),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_double    (d_double),
        .d_rd_odd    (d_rd_odd),
        .d_addr      (d_addr),
        .d_wdata0    (d_wdata0),
        .d_wdata1    (d_wdata1),
        .d_ack       (d_ack),
        .d_exception (d_exception),
        .d_rdata0    (d_rdata0),
        .d_rdata1    (d_rdata1),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_wait(perf_if_wait),
        .perf_d_wait (perf_d_wait)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: 256 words, synchronous read, preloaded once.
    logic [31:0] mem [256];
    logic        loaded = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h10] <= 32'hAABBCCDD;
            mem[8'h20] <= 32'h12345678;
            mem[8'h30] <= 32'h00000001;
            mem[8'h31] <= 32'h00000002;
            loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic        rst;
        logic        ifr;
        logic [31:0] ifa;
        logic        dr, we, dbl, odd;
        logic [31:0] da, w0, w1;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_ia;
        logic [31:0] e_ird;
        logic        e_dk, e_ex;
        logic [31:0] e_r0, e_r1;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic if_pend = 1'b0;
    logic d_pend  = 1'b0;

    function automatic vec_t mk(
        int ifr, logic [31:0] ifa,
        int dr, int we, int dbl, int odd,
        logic [31:0] da, logic [31:0] w0, logic [31:0] w1,
        int en, int mwe, logic [31:0] ma, logic [31:0] mwd,
        int ia, logic [31:0] ird, int dk, int ex,
        logic [31:0] r0, logic [31:0] r1);
        vec_t v;
        v.rst = 1'b1;
        v.ifr = (ifr != 0); v.ifa = ifa;
        v.dr = (dr != 0); v.we = (we != 0);
        v.dbl = (dbl != 0); v.odd = (odd != 0);
        v.da = da; v.w0 = w0; v.w1 = w1;
        v.e_en = (en != 0); v.e_we = (mwe != 0);
        v.e_addr = ma; v.e_wd = mwd;
        v.e_ia = (ia != 0); v.e_ird = ird;
        v.e_dk = (dk != 0); v.e_ex = (ex != 0);
        v.e_r0 = r0; v.e_r1 = r1;
        return v;
    endfunction

    function automatic vec_t idl(logic [31:0] r0, logic [31:0] r1);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endfunction

    task automatic chk(string nm, int idx,
                       logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic step(vec_t v, int idx);
        @(negedge clk);
        if (v.rst && if_pend) begin
            n_tests++;
            if (!v.ifr) begin
                n_fail++;
                $display("FAIL proto_if_drop[%0d]: req 0 want 1", idx);
            end
        end
        if (v.rst && d_pend) begin
            n_tests++;
            if (!v.dr) begin
                n_fail++;
                $display("FAIL proto_d_drop[%0d]: req 0 want 1", idx);
            end
        end
        reset    = v.rst;
        if_req   = v.ifr;
        if_addr  = v.ifa;
        d_req    = v.dr;
        d_we     = v.we;
        d_double = v.dbl;
        d_rd_odd = v.odd;
        d_addr   = v.da;
        d_wdata0 = v.w0;
        d_wdata1 = v.w1;
        #1;
        chk("mem_en", idx, 32'(mem_en), 32'(v.e_en));
        if (v.e_en) begin
            chk("mem_we", idx, 32'(mem_we), 32'(v.e_we));
            chk("mem_addr", idx, mem_addr, v.e_addr);
            if (v.e_we) chk("mem_wdata", idx, mem_wdata, v.e_wd);
        end
        chk("if_ack", idx, 32'(if_ack), 32'(v.e_ia));
        if (v.e_ia) chk("if_rdata", idx, if_rdata, v.e_ird);
        chk("d_ack", idx, 32'(d_ack), 32'(v.e_dk));
        chk("d_exc", idx, 32'(d_exception), 32'(v.e_ex));
        chk("d_rdata0", idx, d_rdata0, v.e_r0);
        chk("d_rdata1", idx, d_rdata1, v.e_r1);
        if_pend = v.rst && v.ifr && !if_ack;
        d_pend  = v.rst && v.dr && !d_ack;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;

        // Reset state.
        v = idl(0, 0); v.rst = 1'b0; step(v, 900);
        v = idl(0, 0); v.rst = 1'b0; step(v, 901);

        // Fetch only.
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 1, 'hAABBCCDD, 0, 0, 0, 0));
        tbl.push_back(idl(0, 0));
        // LW 0x20, then SW, then LW readback.
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                         1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(idl('h12345678, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 'h20, 'hCAFE0001, 0,
                         1, 1, 'h20, 'hCAFE0001, 0, 0, 0, 0,
                         'h12345678, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 'h20, 'hCAFE0001, 0,
                         0, 0, 0, 0, 0, 0, 1, 0, 'h12345678, 0));
        tbl.push_back(idl('h12345678, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                         1, 0, 'h20, 0, 0, 0, 0, 0, 'h12345678, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 0, 'h12345678, 0));
        tbl.push_back(idl('hCAFE0001, 0));
        // LDW 0x30.
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 'h30, 0, 0,
                         1, 0, 'h30, 0, 0, 0, 0, 0, 'hCAFE0001, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 'h30, 0, 0,
                         1, 0, 'h31, 0, 0, 0, 0, 0, 'hCAFE0001, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 'h30, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(idl(1, 2));
        // SDW at the top address wraps beat 1 to 0.
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 'hFFFFFFFF, 'h55, 'h66,
                         1, 1, 'hFFFFFFFF, 'h55, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 'hFFFFFFFF, 'h55, 'h66,
                         1, 1, 0, 'h66, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 'hFFFFFFFF, 'h55, 'h66,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        tbl.push_back(idl(1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        tbl.push_back(idl('h66, 2));
        // Odd destination: exception, no memory access.
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 'h30, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 'h66, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 'h30, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 1, 'h66, 2));
        tbl.push_back(idl('h66, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 'h40, 7, 8,
                         0, 0, 0, 0, 0, 0, 0, 0, 'h66, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 'h40, 7, 8,
                         0, 0, 0, 0, 0, 0, 1, 1, 'h66, 2));
        tbl.push_back(idl('h66, 2));

        foreach (tbl[i]) step(tbl[i], i);

        // Round-robin with both requesting right after reset.
        v = idl(0, 0); v.rst = 1'b0; step(v, 100);
        for (int k = 0; k < 2; k++) begin
            step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                    1, 0, 'h20, 0, 0, 0, 0, 0,
                    (k == 0) ? 32'h0 : 32'hCAFE0001, 0), 101 + 4 * k);
            step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                    0, 0, 0, 0, 0, 0, 1, 0,
                    (k == 0) ? 32'h0 : 32'hCAFE0001, 0), 102 + 4 * k);
            step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                    1, 0, 'h10, 0, 0, 0, 0, 0, 'hCAFE0001, 0),
                 103 + 4 * k);
            step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                    0, 0, 0, 0, 1, 'hAABBCCDD, 0, 0, 'hCAFE0001, 0),
                 104 + 4 * k);
        end
        step(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                1, 0, 'h20, 0, 0, 0, 0, 0, 'hCAFE0001, 0), 109);
        step(mk(0, 0, 1, 0, 0, 0, 'h20, 0, 0,
                0, 0, 0, 0, 0, 0, 1, 0, 'hCAFE0001, 0), 110);
        step(idl('hCAFE0001, 0), 111);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_wait", 111, perf_if_wait, 32'd6);
        chk("perf_d_wait", 111, perf_d_wait, 32'd7);
`endif

        // Reset while in D1_WAIT drops the access without an ack.
        step(mk(0, 0, 1, 0, 1, 0, 'h30, 0, 0,
                1, 0, 'h30, 0, 0, 0, 0, 0, 'hCAFE0001, 0), 200);
        step(mk(0, 0, 1, 0, 1, 0, 'h30, 0, 0,
                1, 0, 'h31, 0, 0, 0, 0, 0, 'hCAFE0001, 0), 201);
        v = idl(0, 0); v.rst = 1'b0; step(v, 202);
        v = idl(0, 0); v.rst = 1'b0; step(v, 203);
        step(idl(0, 0), 204);
`ifdef ARB_PERF_CNT_EN
        chk("perf_if_rst", 204, perf_if_wait, 32'd0);
        chk("perf_d_rst", 204, perf_d_wait, 32'd0);
`endif
        // After reset data wins the first tie again.
        step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                1, 0, 'h20, 0, 0, 0, 0, 0, 0, 0), 205);
        step(mk(1, 'h10, 1, 0, 0, 0, 'h20, 0, 0,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 206);
        step(mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0,
                1, 0, 'h10, 0, 0, 0, 0, 0, 'hCAFE0001, 0), 207);
        step(mk(1, 'h10, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 1, 'hAABBCCDD, 0, 0, 'hCAFE0001, 0), 208);
        step(idl('hCAFE0001, 0), 209);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
Shares one single-port, word-addressed, synchronous-read memory between the pipeline fetch stage (IF) and the memory stage (MEM). Sequences single-word LW/SW accesses and two-beat LDW/SDW double-word accesses. Raises the LDW/SDW odd-destination exception without touching memory. Acknowledges each requester so the pipeline control stalls the stage whose request is still pending.

Parameters:
ADDR_W, 32, word-address width
DATA_W, 32, data word width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch word address
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_W  fetched instruction (mem_rdata pass-through)
d_req  in  1  data request; held, with all d_* inputs stable, until d_ack
d_we  in  1  1 = store (SW/SDW), 0 = load (LW/LDW)
d_double  in  1  1 = LDW/SDW two-beat access
d_rd_odd  in  1  destination/source register index is odd
d_addr  in  ADDR_W  data word address
d_wdata0, d_wdata1  in  DATA_W  store words for beat 0 and beat 1
d_ack  out  1  one-cycle completion pulse
d_exception  out  1  pulses with d_ack when d_double && d_rd_odd
d_rdata0, d_rdata1  out  DATA_W  registered load words; held until the next load completes
mem_en, mem_we  out  1  memory strobe and write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en

Behaviour:
- States: IDLE, IF_WAIT, D0_WAIT, D1_WAIT, EXC.
- Reset:
  - state=IDLE and last_grant=IF, so data wins the first tie.
  - All strobes/acks are 0; d_rdata0/1 are 0.
- IDLE, arbitration:
  - Only one requester: it wins.
  - Both requesting: the requester not granted last time wins (round-robin).
- IDLE, data win:
  - If d_double && d_rd_odd: go to EXC with no memory access.
  - Otherwise issue beat 0 combinationally (mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata0) and go to D0_WAIT.
- IDLE, fetch win: issue mem_en=1, mem_we=0, mem_addr=if_addr; go to IF_WAIT.
- IF_WAIT: if_ack=1, if_rdata=mem_rdata; go to IDLE. A fetch takes 2 cycles from grant to ack.
- D0_WAIT:
  - Load: capture d_rdata0<=mem_rdata.
  - If d_double: issue beat 1 at mem_addr=d_addr+1 (wraps modulo 2^ADDR_W) with mem_wdata=d_wdata1; go to D1_WAIT.
  - Otherwise: d_ack=1; go to IDLE.
- D1_WAIT: load captures d_rdata1<=mem_rdata; d_ack=1; go to IDLE. A double access takes 3 cycles.
- EXC: d_ack=1, d_exception=1; go to IDLE. d_rdata0/1 unchanged.
- last_grant updates on every grant (EXC counts as a data grant).
- There is no back-to-back issue: IDLE always separates accesses.
- A request that drops before its ack is a protocol violation. The bench must flag it; the RTL completes the access anyway.
- Reset asserted mid-access: immediate return to IDLE, outstanding access dropped, no ack.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined:
  - Adds outputs perf_if_wait and perf_d_wait, 32-bit each, reset to 0.
  - Each counts cycles its requester is asserted without its ack, and saturates at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_mem_pkg holds:
  - the state enum (IDLE, IF_WAIT, D0_WAIT, D1_WAIT, EXC)
  - the grant enum (GRANT_IF, GRANT_D)
  - ADDR_W/DATA_W defaults
- Sub-module sat_counter (parameterized width, increment enable, saturate) is used twice under ARB_PERF_CNT_EN.
- The arbiter FSM stays in the top module.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x10, mem[0x10]=0xAABBCCDD -> mem_en at grant cycle, if_ack and if_rdata=0xAABBCCDD one cycle later; d_ack stays 0.
2. LW then SW:
   - LW at d_addr=0x20 (mem=0x12345678) -> d_ack after 2 cycles, d_rdata0=0x12345678.
   - SW d_wdata0=0xCAFE0001 -> mem[0x20]=0xCAFE0001.
3. LDW at d_addr=0x30 with d_rd_odd=0 (mem[0x30]=1, mem[0x31]=2):
   - mem_addr sequence is 0x30 then 0x31.
   - d_ack in cycle 3 with d_rdata0=1, d_rdata1=2.
   - SDW at ADDR all-ones wraps beat 1 to 0x0.
4. LDW/SDW with d_rd_odd=1 -> d_ack=d_exception=1 one cycle after grant; mem_en never asserted; d_rdata unchanged.
5. Simultaneous if_req and d_req held after reset -> grants D, IF, D, IF alternating; neither requester waits more than one access.
6. Reset dropped to 0 while in D1_WAIT -> state IDLE, no d_ack. With ARB_PERF_CNT_EN, perf counters read 0 after reset and equal the stall cycles from scenario 5.
